// File: rtl/mult_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_sequencer
//
// Iterative multiply controller for the execute stage. A mult/multu issued
// from E is run through a radix-2 shift-add datapath, one multiplier bit per
// cycle, and the 2*WIDTH-bit product is committed to the HI/LO registers that
// feed the E-stage output mux. While an operation is in flight the block
// raises a stall towards the hazard unit for any instruction in E that wants
// to start another multiply or read HI/LO.
//
// Signed operation multiplies magnitudes and fixes the sign at the end, so
// the iterative datapath is purely unsigned.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (0 = reset)
//   start      multiply request from E
//   sign       1 = signed (mult), 0 = unsigned (multu); sampled with start
//   src_a      multiplicand (forwarded E operand A)
//   src_b      multiplier   (forwarded E operand B)
//   hilo_read  instruction in E reads HI or LO
//   flush      abort an in-flight multiply
//   busy       operation in progress (RUN or FIX)
//   done       one-cycle pulse in the cycle after HI/LO are written
//   stall      multiply stall to the hazard unit
//   hi, lo     HI (upper half) and LO (lower half) of the last product
// -----------------------------------------------------------------------------
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_read,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of a WIDTH-bit operand. The most negative value maps onto
    // itself, which is exactly right once it is read as an unsigned number.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic [WIDTH-1:0] value,
        input logic             is_signed
    );
        logic [WIDTH-1:0] mag;
        if (is_signed && value[WIDTH-1]) begin
            mag = (~value) + WIDTH'(1);
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    // Two's-complement negation of the full product, wrapping mod 2^(2*WIDTH).
    function automatic logic [PW-1:0] negate_product(
        input logic [PW-1:0] value
    );
        return (~value) + PW'(1);
    endfunction

    state_t           state_r;
    logic [PW-1:0]    mcand_r;    // multiplicand, pre-shifted by the iteration count
    logic [WIDTH-1:0] mplier_r;   // multiplier, consumed LSB first
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic             neg_s;
    logic [PW-1:0]    acc_next_s;
    logic [PW-1:0]    result_s;

    // Operand conditioning at issue time and the per-iteration datapath.
    always_comb begin
        mag_a_s    = magnitude(src_a, sign);
        mag_b_s    = magnitude(src_b, sign);
        neg_s      = sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        acc_next_s = acc_r;
        result_s   = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        if (neg_r) begin
            result_s = negate_product(acc_r);
        end else begin
            result_s = acc_r;
        end
    end

    // Sequencer FSM, datapath registers and HI/LO commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // A flushed instruction must not launch a multiply.
                    if (start && !flush) begin
                        mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
                        mplier_r <= mag_b_s;
                        neg_r    <= neg_s;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    done_r <= 1'b0;
                    if (flush) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        cnt_r    <= cnt_r + CW'(1);
                        busy_r   <= 1'b1;
                        // The last multiplier bit is consumed on this edge.
                        if (cnt_r == LAST_CNT) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_FIX: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                    if (flush) begin
                        done_r <= 1'b0;
                    end else begin
                        hi_r   <= result_s[PW-1:WIDTH];
                        lo_r   <= result_s[WIDTH-1:0];
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // The stall must react to the instruction currently in E, so it combines
    // the registered busy flag with this cycle's requests.
    assign stall = busy_r & (start | hilo_read);
    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule
